// File: rtl/pwm_multi_pkg.sv
// Shared types and default sizing for the multi-channel PWM generator.
// Pure declarations: no latency, no backpressure.
package pwm_multi_pkg;

  localparam int C_DEF_COUNTER_WIDTH = 32;
  localparam int C_DEF_NUM_CHANNELS  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: duty shadow, unsigned compare against the shared count, polarity output register.
// pwm follows count with 1 cycle latency; no backpressure.
module pwm_channel_cmp
  import pwm_multi_pkg::*;
#(
  parameter int C_COUNTER_WIDTH = C_DEF_COUNTER_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [C_COUNTER_WIDTH-1:0] duty_in,
  input  logic                       enable,
  input  logic [C_COUNTER_WIDTH-1:0] count,
  input  logic                       polarity,
  output logic                       pwm
);

  logic [C_COUNTER_WIDTH-1:0] duty_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_sh <= '0;
      pwm     <= 1'b0;
    end else begin
      if (load) begin
        duty_sh <= duty_in;
      end
      pwm <= (enable && (count <= duty_sh)) ^ polarity;
    end
  end

endmodule

// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM with one shared period counter and boundary-synchronous shadow reload; pwm lags count by 1 cycle, no backpressure.
// Center-aligned (up/down) counting is built only when PWM_CENTER_ALIGN_EN is defined.
module pwm_multi_generator
  import pwm_multi_pkg::*;
#(
  parameter int C_COUNTER_WIDTH = C_DEF_COUNTER_WIDTH,
  parameter int C_NUM_CHANNELS  = C_DEF_NUM_CHANNELS
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      stop,
  input  logic                                      update,
  input  logic [C_COUNTER_WIDTH-1:0]                period_cnt,
  input  logic [C_NUM_CHANNELS*C_COUNTER_WIDTH-1:0] duty_cnt,
  input  logic [C_NUM_CHANNELS-1:0]                 polarity,
  input  logic                                      center_mode,
  output logic [C_NUM_CHANNELS-1:0]                 pwm,
  output logic                                      running,
  output logic                                      period_done
);

  localparam int W = C_COUNTER_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  state_t         state;
  logic [W-1:0]   count;
  logic [W-1:0]   period_sh;
  logic [W-1:0]   p_eff;
  logic           pending;
  logic           start_q;
  logic           stop_q;
  logic           start_edge;
  logic           stop_edge;
  logic           boundary;
  logic           load_sh;
  logic           in_run;

`ifdef PWM_CENTER_ALIGN_EN
  localparam logic [W-1:0] TWO = W'(2);
  logic mode_sh;
  logic dir_down;
`else
  logic unused_center_mode;
  assign unused_center_mode = center_mode;
`endif

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop & ~stop_q;
  assign in_run     = (state == RUN);

  // Boundary is the last edge-mode count, or the down-count arrival at 1 in center mode.
  always_comb begin
    p_eff    = period_sh;
    boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    if (mode_sh) begin
      if (period_sh < TWO) p_eff = TWO;
      boundary = dir_down && (count == ONE);
    end else begin
      if (period_sh == '0) p_eff = ONE;
      boundary = (count >= p_eff);
    end
`else
    if (period_sh == '0) p_eff = ONE;
    boundary = (count >= p_eff);
`endif
  end

  assign load_sh     = ~stop_edge & (start_edge | (in_run & boundary & pending));
  assign running     = in_run;
  assign period_done = in_run & boundary;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      period_sh <= '0;
      pending   <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      mode_sh   <= 1'b0;
      dir_down  <= 1'b0;
`endif
    end else begin
      start_q <= start;
      stop_q  <= stop;
      if (load_sh) begin
        period_sh <= period_cnt;
`ifdef PWM_CENTER_ALIGN_EN
        mode_sh   <= center_mode;
`endif
      end
      if (stop_edge) begin
        state   <= IDLE;
        count   <= '0;
        pending <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_down <= 1'b0;
`endif
      end else begin
        pending <= (in_run & update) | (pending & ~(in_run & boundary));
        if (start_edge) begin
          state <= RUN;
          count <= ONE;
`ifdef PWM_CENTER_ALIGN_EN
          dir_down <= 1'b0;
`endif
        end else if (in_run) begin
`ifdef PWM_CENTER_ALIGN_EN
          if (mode_sh) begin
            if (dir_down) begin
              if (count == ONE) begin
                dir_down <= 1'b0;
                count    <= count + ONE;
              end else begin
                count <= count - ONE;
              end
            end else if (count >= p_eff) begin
              dir_down <= 1'b1;
              count    <= count - ONE;
            end else begin
              count <= count + ONE;
            end
          end else begin
            count <= boundary ? ONE : count + ONE;
          end
`else
          count <= boundary ? ONE : count + ONE;
`endif
        end
      end
    end
  end

  // Output is forced inactive in the stop cycle so pwm shows polarity as soon as state reads IDLE.
  for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_ch
    pwm_channel_cmp #(
      .C_COUNTER_WIDTH(W)
    ) u_cmp (
      .clk     (clk),
      .reset   (reset),
      .load    (load_sh),
      .duty_in (duty_cnt[i*W +: W]),
      .enable  (in_run & ~stop_edge),
      .count   (count),
      .polarity(polarity[i]),
      .pwm     (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Directed and randomized checks of pwm_multi_generator against a phase-based reference model.
module tb_pwm_multi_generator;

  logic         clk;
  logic         reset;
  logic         start;
  logic         stop;
  logic         update;
  logic [31:0]  period_cnt;
  logic [127:0] duty_cnt;
  logic [3:0]   polarity;
  logic         center_mode;
  logic [3:0]   pwm;
  logic         running;
  logic         period_done;

  int tests = 0;
  int fails = 0;

  // Reference model: position within the current period plus shadow values.
  bit          m_run, m_first, m_pend, m_sq, m_pq, m_mode;
  int unsigned m_t, m_P;
  int unsigned m_D [4];
  logic [3:0]  m_pwm;

  pwm_multi_generator #(
    .C_COUNTER_WIDTH(32),
    .C_NUM_CHANNELS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .update     (update),
    .period_cnt (period_cnt),
    .duty_cnt   (duty_cnt),
    .polarity   (polarity),
    .center_mode(center_mode),
    .pwm        (pwm),
    .running    (running),
    .period_done(period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned m_peff();
    if (m_mode) return (m_P < 2) ? 2 : m_P;
    return (m_P == 0) ? 1 : m_P;
  endfunction

  function automatic int unsigned m_len();
    return m_mode ? 2 * m_peff() - 2 : m_peff();
  endfunction

  function automatic int unsigned m_count();
    int unsigned pe;
    pe = m_peff();
    if (!m_mode) return m_t + 1;
    return (m_t < pe) ? m_t + 1 : 2 * pe - 1 - m_t;
  endfunction

  function automatic bit m_bnd();
    if (!m_run) return 1'b0;
    if (m_mode) return (m_t == 0) && !m_first;
    return m_t == m_len() - 1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_first = 0; m_pend = 0; m_sq = 0; m_pq = 0; m_mode = 0;
    m_t = 0; m_P = 0; m_pwm = 4'b0;
    for (int i = 0; i < 4; i++) m_D[i] = 0;
  endtask

  task automatic model_load();
    m_P = period_cnt;
    for (int i = 0; i < 4; i++) m_D[i] = duty_cnt[i*32 +: 32];
`ifdef PWM_CENTER_ALIGN_EN
    m_mode = center_mode;
`else
    m_mode = 1'b0;
`endif
  endtask

  task automatic model_step();
    bit se, pe, bnd, newpend;
    int unsigned cnt, len;
    if (reset) begin
      model_reset();
      return;
    end
    se  = start && !m_sq;
    pe  = stop && !m_pq;
    bnd = m_bnd();
    cnt = m_count();
    len = m_len();
    for (int i = 0; i < 4; i++)
      m_pwm[i] = ((m_run && !pe && cnt <= m_D[i]) ? 1'b1 : 1'b0) ^ polarity[i];
    m_sq = start;
    m_pq = stop;
    if (pe) begin
      m_run  = 0;
      m_pend = 0;
    end else begin
      newpend = (m_run && update) || (m_pend && !bnd);
      if (se) begin
        m_run = 1; m_t = 0; m_first = 1;
        model_load();
      end else if (m_run) begin
        if (m_mode) begin
          m_t     = (m_t == len - 1) ? 0 : m_t + 1;
          m_first = 0;
        end else begin
          m_t = bnd ? 0 : m_t + 1;
        end
        if (bnd && m_pend) model_load();
      end
      m_pend = newpend;
    end
  endtask

  task automatic check_outputs();
    logic exp_pd;
    exp_pd = m_bnd();
    tests++;
    assert (pwm === m_pwm) else begin
      fails++;
      $error("FAIL pwm got=%b exp=%b at %0t", pwm, m_pwm, $time);
    end
    tests++;
    assert (running === m_run) else begin
      fails++;
      $error("FAIL running got=%b exp=%b at %0t", running, m_run, $time);
    end
    tests++;
    assert (period_done === exp_pd) else begin
      fails++;
      $error("FAIL period_done got=%b exp=%b at %0t", period_done, exp_pd, $time);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_duty(input int ch, input int unsigned v);
    duty_cnt[ch*32 +: 32] = v;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
  endtask

  initial begin
    int hi [4];
    int pd_first, pd_second, cyc, hi_a, hi_b;
    logic [9:0] pw, pdv;

    reset = 1'b1; start = 0; stop = 0; update = 0; center_mode = 0;
    period_cnt = 0; duty_cnt = '0; polarity = 4'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    chk("rst_pwm", pwm, 0);
    chk("rst_running", running, 0);
    chk("rst_pd", period_done, 0);
    polarity = 4'b1010;
    tick();
    chk("rst_hold_pwm", pwm, 0);
    reset = 1'b0;
    tick();
    chk("rst_release_pol", pwm, 4'b1010);
    polarity = 4'b0;
    tick();

    // Basic edge-aligned waveform: P=5, D0=2.
    period_cnt = 5; set_duty(0, 2);
    start = 1;
    tick();
    chk("p5_running_c1", running, 1);
    pw = '0; pdv = '0;
    for (int c = 2; c <= 11; c++) begin
      tick();
      pw  = {pw[8:0], pwm[0]};
      pdv = {pdv[8:0], period_done};
    end
    chk("p5_pwm0_pattern", 32'(pw), 32'(10'b1100011000));
    chk("p5_pd_pattern", 32'(pdv), 32'(10'b0001000010));

    // Duty extremes, then polarity inversion while inputs change without update.
    start = 0; stop = 1; tick();
    stop = 0; tick();
    period_cnt = 5; set_duty(0, 0); set_duty(1, 5); set_duty(2, 9); set_duty(3, 3);
    start = 1; tick(); tick();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    repeat (10) begin
      for (int i = 0; i < 4; i++) hi[i] += pwm[i];
      tick();
    end
    chk("dext_ch0", hi[0], 0);
    chk("dext_ch1", hi[1], 10);
    chk("dext_ch2", hi[2], 10);
    chk("dext_ch3", hi[3], 6);
    period_cnt = 3;
    for (int i = 0; i < 4; i++) set_duty(i, $urandom_range(0, 14));
    polarity = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    repeat (10) begin
      for (int i = 0; i < 4; i++) hi[i] += pwm[i];
      tick();
    end
    chk("inv_ch0", hi[0], 10);
    chk("inv_ch1", hi[1], 0);
    chk("inv_ch2", hi[2], 0);
    chk("inv_ch3", hi[3], 4);

    // Update mid-period takes effect only at the boundary.
    stop = 1; start = 0; tick();
    stop = 0; polarity = 0; period_cnt = 10; duty_cnt = '0; set_duty(0, 4); tick();
    start = 1; tick(); tick(); tick();
    update = 1; period_cnt = 6; set_duty(0, 1);
    tick();
    update = 0;
    pd_first = -1; pd_second = -1; hi_a = 0; hi_b = 0; cyc = 4;
    repeat (19) begin
      if (period_done) begin
        if (pd_first < 0) pd_first = cyc;
        else if (pd_second < 0) pd_second = cyc;
      end
      if (pwm[0]) begin
        if (cyc <= 10) hi_a++;
        else hi_b++;
      end
      tick();
      cyc++;
    end
    chk("upd_pd_first", pd_first, 10);
    chk("upd_pd_second", pd_second, 16);
    chk("upd_hi_before", hi_a, 2);
    chk("upd_hi_after", hi_b, 2);

    // Simultaneous start and stop edges: stop wins.
    start = 0; polarity = 4'b0110; tick();
    start = 1; stop = 1; tick();
    chk("ss_running", running, 0);
    chk("ss_pwm", pwm, 4'b0110);
    chk("ss_pd", period_done, 0);
    start = 0; stop = 0; tick();

    // Asynchronous reset mid-period, then restart only on a fresh edge.
    start = 1; tick(); tick(); tick();
    chk("ar_pre_running", running, 1);
    async_reset();
    chk("ar_pwm", pwm, 0);
    chk("ar_running", running, 0);
    chk("ar_pd", period_done, 0);
    start = 0; tick();
    reset = 0;
    repeat (4) tick();
    chk("ar_idle_running", running, 0);
    chk("ar_idle_pwm", pwm, 4'b0110);
    start = 1; tick();
    chk("ar_restart", running, 1);

`ifdef PWM_CENTER_ALIGN_EN
    // Center-aligned: P=4, D0=2, 6-cycle period.
    start = 0; stop = 1; tick();
    stop = 0; center_mode = 1; period_cnt = 4; duty_cnt = '0; set_duty(0, 2); polarity = 0; tick();
    start = 1; tick(); tick(); tick(); tick();
    pd_first = -1; pd_second = -1; hi_a = 0; cyc = 4;
    repeat (12) begin
      if (period_done) begin
        if (pd_first < 0) pd_first = cyc;
        else if (pd_second < 0) pd_second = cyc;
      end
      hi_a += pwm[0];
      tick();
      cyc++;
    end
    chk("ctr_hi", hi_a, 6);
    chk("ctr_pd_first", pd_first, 7);
    chk("ctr_pd_second", pd_second, 13);
    center_mode = 0; start = 0; stop = 1; tick();
    stop = 0; tick();
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) start = ~start;
      if (r >= 96) stop = ~stop;
      update = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin
        period_cnt = $urandom_range(0, 12);
        for (int i = 0; i < 4; i++) set_duty(i, $urandom_range(0, 14));
      end
      if ($urandom_range(0, 49) == 0) polarity = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        tick();
        reset = 0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
